fwd_hazard_unit: RTL and testbench

Parametrised forwarding and load-use hazard unit for the pipelined core. It sits beside the ID/EX boundary and tracks destination registers of in-flight instructions in an internal shadow pipeline. It produces registered per-operand forwarding selects for the instruction entering EX, and a combinational stall for load-use hazards. It replaces single-pair address comparison with multi-stage, multi-operand priority forwarding plus a stall statistic.

---
 rtl/fwd_pkg.sv | 15 +
 rtl/fwd_hazard_unit_match.sv | 43 ++++
 rtl/fwd_hazard_unit.sv | 102 ++++++++++
 tb/tb_fwd_hazard_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
package fwd_pkg;

  localparam int RD_MAX_W = 8;
  localparam int FWD_RF   = 0;

  // rd is stored zero-extended so one struct serves every ADDR_W up to RD_MAX_W
  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                regwrite;
    logic                is_load;
  } entry_t;

endpackage

// File: rtl/fwd_hazard_unit_match.sv
// One source operand against the comparable tracked entries: youngest-match
// forwarding select and load-use hazard flag.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int ADDR_W     = 3,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic [ADDR_W-1:0]  src,
  input  logic               used,
  input  entry_t [DEPTH-2:0] entries,
  output logic [SEL_W-1:0]   sel,
  output logic               load_hazard
);

  logic             zero_src_s;
  logic [DEPTH-2:0] hit_s;

  assign zero_src_s = (ZERO_REG != 0) && (src == {ADDR_W{1'b0}});

  // per-entry address match
  always_comb begin
    hit_s = '0;
    for (int j = 0; j <= DEPTH - 2; j++) begin
      hit_s[j] = used && !zero_src_s && entries[j].valid && entries[j].regwrite &&
                 (entries[j].rd == RD_MAX_W'(src));
    end
  end

  // oldest-to-youngest scan so the youngest hit overwrites older ones
  always_comb begin
    sel         = SEL_W'(FWD_RF);
    load_hazard = 1'b0;
    for (int j = DEPTH - 2; j >= 0; j--) begin
      sel         = hit_s[j] ? SEL_W'(j + 1) : sel;
      load_hazard = hit_s[j] ? (entries[j].is_load && (j + 1 < LOAD_STAGE)) : load_hazard;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: shadow pipeline of in-flight
// destinations, registered per-operand forwarding selects, combinational stall.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int ADDR_W     = 3,
  parameter int NSRC       = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = $clog2(DEPTH),
  parameter int ZERO_REG   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [ADDR_W-1:0]      id_rd,
  input  logic                   id_regwrite,
  input  logic                   id_is_load,
  input  logic [NSRC*ADDR_W-1:0] id_src,
  input  logic [NSRC-1:0]        id_src_used,
  input  logic                   flush,
  output logic                   stall,
  output logic [NSRC*SEL_W-1:0]  ex_fwd_sel,
  output logic [15:0]            stall_count
);

  entry_t [DEPTH-1:0]    ent_r;
  entry_t                entry_in_s;
  logic [NSRC-1:0]       hazard_s;
  logic [NSRC*SEL_W-1:0] sel_s;
  logic                  issue_s;
  logic                  unused_wb_s;

  // The WB entry is tracked only to keep the shadow pipeline aligned.
  assign unused_wb_s = ^ent_r[DEPTH-1];

  for (genvar i = 0; i < NSRC; i++) begin : g_match
    fwd_match #(
      .ADDR_W     (ADDR_W),
      .DEPTH      (DEPTH),
      .LOAD_STAGE (LOAD_STAGE),
      .SEL_W      (SEL_W),
      .ZERO_REG   (ZERO_REG)
    ) u_match (
      .src         (id_src[i*ADDR_W +: ADDR_W]),
      .used        (id_src_used[i]),
      .entries     (ent_r[DEPTH-2:0]),
      .sel         (sel_s[i*SEL_W +: SEL_W]),
      .load_hazard (hazard_s[i])
    );
  end

  assign stall   = id_valid && !flush && (|hazard_s);
  assign issue_s = id_valid && !stall && !flush;

  // new EX entry: the decoded instruction or a bubble
  always_comb begin
    entry_in_s = '0;
    if (issue_s) begin
      entry_in_s.valid    = 1'b1;
      entry_in_s.rd       = RD_MAX_W'(id_rd);
      entry_in_s.regwrite = id_regwrite;
      entry_in_s.is_load  = id_is_load;
    end else begin
      entry_in_s = '0;
    end
  end

  // shadow pipeline shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_r <= '0;
    end else if (flush) begin
      ent_r <= '0;
    end else begin
      ent_r <= {ent_r[DEPTH-2:0], entry_in_s};
    end
  end

  // forwarding selects for the instruction entering EX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_fwd_sel <= '0;
    end else if (flush || stall || !id_valid) begin
      ex_fwd_sel <= '0;
    end else begin
      ex_fwd_sel <= sel_s;
    end
  end

  // saturating stall statistic
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= 16'h0000;
    end else if (stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'h0001;
    end else begin
      stall_count <= stall_count;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit at default parameters.
module tb_fwd_hazard_unit;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [2:0]  id_rd;
  logic        id_regwrite;
  logic        id_is_load;
  logic [5:0]  id_src;
  logic [1:0]  id_src_used;
  logic        flush;
  logic        stall;
  logic [3:0]  ex_fwd_sel;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  fwd_hazard_unit dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_is_load  (id_is_load),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .flush       (flush),
    .stall       (stall),
    .ex_fwd_sel  (ex_fwd_sel),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [2:0] rd, input logic rw, input logic ld,
                        input logic [2:0] s0, input logic [2:0] s1, input logic [1:0] used);
    id_valid    = v;
    id_rd       = rd;
    id_regwrite = rw;
    id_is_load  = ld;
    id_src      = {s1, s0};
    id_src_used = used;
  endtask

  task automatic idle(input int n);
    set_id(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    set_id(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00);
    #2;
    checks++; if (ex_fwd_sel !== 4'b0000) begin errors++; $display("FAIL por_sel: got %b expected %b", ex_fwd_sel, 4'b0000); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL por_count: got %0d expected %0d", stall_count, 0); end
    rst = 1'b0;
    tick();
    set_id(1'b1, 3'd4, 1'b1, 1'b1, 3'd0, 3'd0, 2'b00);
    tick();
    set_id(1'b1, 3'd6, 1'b1, 1'b0, 3'd4, 3'd0, 2'b01);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall: got %b expected %b", stall, 1'b1); end
    tick();
    tick();
    set_id(1'b1, 3'd5, 1'b1, 1'b1, 3'd6, 3'd0, 2'b01);
    tick();
    set_id(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 3'd5, 2'b10);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall2: got %b expected %b", stall, 1'b1); end
    checks++; if (ex_fwd_sel !== 4'b0001) begin errors++; $display("FAIL rst_pre_sel: got %b expected %b", ex_fwd_sel, 4'b0001); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL rst_pre_count: got %0d expected %0d", stall_count, 1); end
    rst = 1'b1;
    #1;
    checks++; if (ex_fwd_sel !== 4'b0000) begin errors++; $display("FAIL rst_sel: got %b expected %b", ex_fwd_sel, 4'b0000); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected %b", stall, 1'b0); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d expected %0d", stall_count, 0); end
    #1;
    rst = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_post_stall: got %b expected %b", stall, 1'b0); end
    tick();
    checks++; if (ex_fwd_sel !== 4'b0000) begin errors++; $display("FAIL rst_post_sel: got %b expected %b", ex_fwd_sel, 4'b0000); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL rst_post_count: got %0d expected %0d", stall_count, 0); end
  endtask

  task automatic test_distance();
    idle(3);
    set_id(1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 3'd0, 2'b00);
    tick();
    set_id(1'b1, 3'd0, 1'b0, 1'b0, 3'd3, 3'd0, 2'b01);
    tick();
    checks++; if (ex_fwd_sel !== 4'b0001) begin errors++; $display("FAIL dist1_sel: got %b expected %b", ex_fwd_sel, 4'b0001); end
    idle(3);
    set_id(1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 3'd0, 2'b00);
    tick();
    idle(1);
    set_id(1'b1, 3'd0, 1'b0, 1'b0, 3'd3, 3'd0, 2'b01);
    tick();
    checks++; if (ex_fwd_sel !== 4'b0010) begin errors++; $display("FAIL dist2_sel: got %b expected %b", ex_fwd_sel, 4'b0010); end
    idle(3);
    set_id(1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 3'd0, 2'b00);
    tick();
    idle(2);
    set_id(1'b1, 3'd0, 1'b0, 1'b0, 3'd3, 3'd0, 2'b01);
    tick();
    checks++; if (ex_fwd_sel !== 4'b0000) begin errors++; $display("FAIL dist3_sel: got %b expected %b", ex_fwd_sel, 4'b0000); end
  endtask

  task automatic test_priority();
    idle(3);
    set_id(1'b1, 3'd5, 1'b1, 1'b0, 3'd0, 3'd0, 2'b00);
    tick();
    tick();
    set_id(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 3'd5, 2'b10);
    tick();
    checks++; if (ex_fwd_sel !== 4'b0100) begin errors++; $display("FAIL prio_youngest: got %b expected %b", ex_fwd_sel, 4'b0100); end
    idle(3);
    set_id(1'b1, 3'd1, 1'b1, 1'b0, 3'd0, 3'd0, 2'b00);
    tick();
    set_id(1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 3'd0, 2'b00);
    tick();
    set_id(1'b1, 3'd0, 1'b0, 1'b0, 3'd1, 3'd2, 2'b11);
    tick();
    checks++; if (ex_fwd_sel !== 4'b0110) begin errors++; $display("FAIL prio_two_ops: got %b expected %b", ex_fwd_sel, 4'b0110); end
  endtask

  task automatic test_load_use();
    idle(3);
    set_id(1'b1, 3'd4, 1'b1, 1'b1, 3'd0, 3'd0, 2'b00);
    tick();
    set_id(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 3'd4, 2'b10);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected %b", stall, 1'b1); end
    tick();
    checks++; if (ex_fwd_sel !== 4'b0000) begin errors++; $display("FAIL lu_bubble_sel: got %b expected %b", ex_fwd_sel, 4'b0000); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_clear: got %b expected %b", stall, 1'b0); end
    tick();
    checks++; if (ex_fwd_sel !== 4'b1000) begin errors++; $display("FAIL lu_sel: got %b expected %b", ex_fwd_sel, 4'b1000); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_count: got %0d expected %0d", stall_count, 1); end
    idle(3);
    set_id(1'b1, 3'd6, 1'b1, 1'b1, 3'd0, 3'd0, 2'b00);
    tick();
    idle(1);
    set_id(1'b1, 3'd0, 1'b0, 1'b0, 3'd6, 3'd0, 2'b01);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_far_stall: got %b expected %b", stall, 1'b0); end
    tick();
    checks++; if (ex_fwd_sel !== 4'b0010) begin errors++; $display("FAIL lu_far_sel: got %b expected %b", ex_fwd_sel, 4'b0010); end
  endtask

  task automatic test_zero_unused();
    idle(3);
    set_id(1'b1, 3'd0, 1'b1, 1'b0, 3'd0, 3'd0, 2'b00);
    tick();
    set_id(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 2'b01);
    tick();
    checks++; if (ex_fwd_sel !== 4'b0000) begin errors++; $display("FAIL x0_alu_sel: got %b expected %b", ex_fwd_sel, 4'b0000); end
    set_id(1'b1, 3'd0, 1'b1, 1'b1, 3'd0, 3'd0, 2'b00);
    tick();
    set_id(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 2'b01);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_load_stall: got %b expected %b", stall, 1'b0); end
    tick();
    checks++; if (ex_fwd_sel !== 4'b0000) begin errors++; $display("FAIL x0_load_sel: got %b expected %b", ex_fwd_sel, 4'b0000); end
    set_id(1'b1, 3'd7, 1'b1, 1'b1, 3'd0, 3'd0, 2'b00);
    tick();
    set_id(1'b1, 3'd0, 1'b0, 1'b0, 3'd7, 3'd7, 2'b00);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL unused_stall: got %b expected %b", stall, 1'b0); end
    tick();
    checks++; if (ex_fwd_sel !== 4'b0000) begin errors++; $display("FAIL unused_sel: got %b expected %b", ex_fwd_sel, 4'b0000); end
    set_id(1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00);
    tick();
    set_id(1'b1, 3'd0, 1'b0, 1'b0, 3'd3, 3'd0, 2'b01);
    tick();
    checks++; if (ex_fwd_sel !== 4'b0000) begin errors++; $display("FAIL norw_sel: got %b expected %b", ex_fwd_sel, 4'b0000); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL zero_count: got %0d expected %0d", stall_count, 1); end
  endtask

  task automatic test_flush();
    idle(3);
    set_id(1'b1, 3'd2, 1'b1, 1'b1, 3'd0, 3'd0, 2'b00);
    tick();
    set_id(1'b1, 3'd2, 1'b1, 1'b0, 3'd2, 3'd0, 2'b01);
    flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected %b", stall, 1'b0); end
    tick();
    checks++; if (ex_fwd_sel !== 4'b0000) begin errors++; $display("FAIL flush_sel: got %b expected %b", ex_fwd_sel, 4'b0000); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL flush_count: got %0d expected %0d", stall_count, 1); end
    flush = 1'b0;
    set_id(1'b1, 3'd0, 1'b0, 1'b0, 3'd2, 3'd0, 2'b01);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_after_stall: got %b expected %b", stall, 1'b0); end
    tick();
    checks++; if (ex_fwd_sel !== 4'b0000) begin errors++; $display("FAIL flush_empty_sel: got %b expected %b", ex_fwd_sel, 4'b0000); end
  endtask

  task automatic test_back_to_back();
    idle(3);
    set_id(1'b1, 3'd1, 1'b1, 1'b0, 3'd0, 3'd0, 2'b00);
    tick();
    set_id(1'b1, 3'd2, 1'b1, 1'b0, 3'd1, 3'd0, 2'b01);
    tick();
    checks++; if (ex_fwd_sel !== 4'b0001) begin errors++; $display("FAIL b2b_1: got %b expected %b", ex_fwd_sel, 4'b0001); end
    set_id(1'b1, 3'd3, 1'b1, 1'b0, 3'd2, 3'd1, 2'b11);
    tick();
    checks++; if (ex_fwd_sel !== 4'b1001) begin errors++; $display("FAIL b2b_2: got %b expected %b", ex_fwd_sel, 4'b1001); end
    set_id(1'b1, 3'd0, 1'b0, 1'b0, 3'd3, 3'd1, 2'b11);
    tick();
    checks++; if (ex_fwd_sel !== 4'b0001) begin errors++; $display("FAIL b2b_3: got %b expected %b", ex_fwd_sel, 4'b0001); end
  endtask

  initial begin
    test_reset();
    test_distance();
    test_priority();
    test_load_use();
    test_zero_unused();
    test_flush();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
